t_flip_flop: RTL and testbench

- Parameterized bank of N independent toggle (T) flip-flops sharing one clock and one reset.
- Bit i of q inverts on a rising clock edge when t[i] is 1. It holds its value when t[i] is 0.
- q_bar always presents the bitwise complement of q.
- Used as a generic per-bit toggle register and counter building block. It is instantiated by position with the width parameter.

---
 rtl/t_flip_flop.sv | 34 +++
 tb/tb_t_flip_flop.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/t_flip_flop.sv
// Bank of N independent toggle flip-flops with a synchronous active-high reset.
// Each bit inverts on a rising clock edge when its t bit is set; q_bar is the complement of q.
module t_flip_flop #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] t,
    output logic [N-1:0] q,
    output logic [N-1:0] q_bar
);

    logic [N-1:0] state;
    logic [N-1:0] state_next;

    // Bitwise XOR keeps the bits fully independent, so an X on one t bit
    // cannot reach any other q bit.
    always_comb begin
        state_next = state ^ t;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
        end else begin
            state <= state_next;
        end
    end

    // q_bar comes from the same register as q, so the two can never agree.
    assign q     = state;
    assign q_bar = ~state;

endmodule

// File: tb/tb_t_flip_flop.sv
// Directed, table-driven check of the toggle flip-flop bank at N=4 and N=8.
module tb_t_flip_flop;

    logic       clk;
    logic       rst4;
    logic [3:0] t4;
    logic [3:0] q4;
    logic [3:0] q_bar4;
    logic       rst8;
    logic [7:0] t8;
    logic [7:0] q8;
    logic [7:0] q_bar8;

    int total;
    int bad;

    typedef struct {
        logic       rst;
        logic [3:0] t;
        logic [3:0] exp_q;
        string      name;
    } vec4_t;

    typedef struct {
        logic       rst;
        logic [7:0] t;
        logic [7:0] exp_q;
        string      name;
    } vec8_t;

    vec4_t vecs4[12];
    vec8_t vecs8[5];

    t_flip_flop #(4) dut4 (
        .clk  (clk),
        .rst  (rst4),
        .t    (t4),
        .q    (q4),
        .q_bar(q_bar4)
    );

    t_flip_flop #(8) dut8 (
        .clk  (clk),
        .rst  (rst8),
        .t    (t8),
        .q    (q8),
        .q_bar(q_bar8)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check4(input string name, input logic [3:0] exp_q);
        total++;
        if (q4 !== exp_q) begin
            bad++;
            $display("FAIL %s q: got %b want %b", name, q4, exp_q);
        end
        total++;
        if (q_bar4 !== ~exp_q) begin
            bad++;
            $display("FAIL %s q_bar: got %b want %b", name, q_bar4, ~exp_q);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] exp_q);
        total++;
        if (q8 !== exp_q) begin
            bad++;
            $display("FAIL %s q: got %h want %h", name, q8, exp_q);
        end
        total++;
        if (q_bar8 !== ~exp_q) begin
            bad++;
            $display("FAIL %s q_bar: got %h want %h", name, q_bar8, ~exp_q);
        end
    endtask

    // Drivers: apply inputs, take one rising edge, then sample 1 time unit later.
    task automatic step4(input logic r, input logic [3:0] tv);
        rst4 = r;
        t4   = tv;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic r, input logic [7:0] tv);
        rst8 = r;
        t8   = tv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] acc;
        logic [3:0] sw;

        total = 0;
        bad   = 0;
        rst4  = 1'b1;
        t4    = 4'b0000;
        rst8  = 1'b1;
        t8    = 8'h00;

        vecs4[0]  = '{1'b1, 4'b1111, 4'b0000, "reset"};
        vecs4[1]  = '{1'b0, 4'b0000, 4'b0000, "hold1"};
        vecs4[2]  = '{1'b0, 4'b0000, 4'b0000, "hold2"};
        vecs4[3]  = '{1'b0, 4'b0000, 4'b0000, "hold3"};
        vecs4[4]  = '{1'b0, 4'b0101, 4'b0101, "sel_a"};
        vecs4[5]  = '{1'b0, 4'b0011, 4'b0110, "sel_b"};
        vecs4[6]  = '{1'b0, 4'b1100, 4'b1010, "set_1010"};
        vecs4[7]  = '{1'b1, 4'b1111, 4'b0000, "rst_prio"};
        vecs4[8]  = '{1'b1, 4'b0110, 4'b0000, "rst_held"};
        vecs4[9]  = '{1'b0, 4'b1000, 4'b1000, "rst_release"};
        vecs4[10] = '{1'b0, 4'b1111, 4'b0111, "all_ones_a"};
        vecs4[11] = '{1'b0, 4'b1111, 4'b1000, "all_ones_b"};

        vecs8[0] = '{1'b1, 8'hFF, 8'h00, "w8_reset"};
        vecs8[1] = '{1'b0, 8'hFF, 8'hFF, "w8_ff_a"};
        vecs8[2] = '{1'b0, 8'hFF, 8'h00, "w8_ff_b"};
        vecs8[3] = '{1'b0, 8'hA5, 8'hA5, "w8_a5"};
        vecs8[4] = '{1'b0, 8'h81, 8'h24, "w8_81"};

        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            step4(vecs4[i].rst, vecs4[i].t);
            check4(vecs4[i].name, vecs4[i].exp_q);
        end

        // Full sweep: q is the XOR-accumulation of every t applied since reset.
        step4(1'b1, 4'b0000);
        check4("sweep_reset", 4'b0000);
        acc = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            sw  = 4'(k);
            acc = acc ^ sw;
            step4(1'b0, sw);
            check4($sformatf("sweep_%0d", k), acc);
        end
        check4("sweep_end", 4'b0000);

        // Reset asserted between edges takes effect only at the next edge.
        step4(1'b0, 4'b0011);
        #2;
        rst4 = 1'b1;
        #1;
        check4("rst_between_edges", 4'b0011);
        @(posedge clk);
        #1;
        check4("rst_after_edge", 4'b0000);

        for (int i = 0; i < 5; i++) begin
            step8(vecs8[i].rst, vecs8[i].t);
            check8(vecs8[i].name, vecs8[i].exp_q);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
